window_gen_nxm: RTL and testbench

Parametrised sliding-window generator for the disparity-map pipeline, successor to the fixed 5x3 window stage. Each accepted input column (WIN_H vertically aligned pixels from the line buffers) is shifted into a WIN_H x WIN_W register array. The block tracks column and row position within the frame and asserts a per-window valid only when every tap holds real pixels of the current line. It sits between the line-buffer bank and the cost/census stages and removes the old block's single warm-up counter, which never deasserted at line starts.

---
 rtl/window_pkg.sv | 17 +
 rtl/win_row_shift.sv | 33 +++
 rtl/window_gen_nxm.sv | 88 ++++++++
 tb/tb_window_gen_nxm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared definitions for the sliding-window generator and the cost blocks that unpack its window.
package window_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } win_state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Bit offset of tap (r, c) inside a packed window bus; c = win_w-1 is the newest pixel.
  function automatic int tap_lsb(input int r, input int c, input int win_w, input int data_w);
    return (r * win_w + c) * data_w;
  endfunction

endpackage

// File: rtl/win_row_shift.sv
// One window row: a WIN_W-deep tap chain that shifts toward tap 0 on clken and holds otherwise.
module win_row_shift
  import window_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int WIN_W  = 3
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    clken,
  input  logic [DATA_W-1:0]       pix_in,
  output logic [WIN_W*DATA_W-1:0] taps
);

  logic [DATA_W-1:0] tap_q [WIN_W];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < WIN_W; c++) tap_q[c] <= '0;
    end else if (clken) begin
      for (int c = 0; c < WIN_W - 1; c++) tap_q[c] <= tap_q[c+1];
      tap_q[WIN_W-1] <= pix_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_W; gi++) begin : g_pack
      assign taps[tap_lsb(0, gi, WIN_W, DATA_W) +: DATA_W] = tap_q[gi];
    end
  endgenerate

endmodule

// File: rtl/window_gen_nxm.sv
// WIN_H x WIN_W sliding-window generator: tap array plus frame position tracking,
// emitting win_valid only when every tap holds pixels of the current line.
module window_gen_nxm
  import window_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int WIN_H   = 5,
  parameter int WIN_W   = 3,
  parameter int WIDTH_W = 11
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          clken,
  input  logic                          sof,
  input  logic [WIDTH_W-1:0]            width,
  input  logic [WIN_H*DATA_W-1:0]       col_in,
  output logic [WIN_H*WIN_W*DATA_W-1:0] win_out,
  output logic                          win_valid,
  output logic [WIDTH_W-1:0]            win_col,
  output logic                          frame_err
);

  localparam int ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN_H - 1);

  win_state_t         state;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] col_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic [WIDTH_W-1:0] width_m1;

  assign width_m1 = width_q - WIDTH_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < WIN_H; gi++) begin : g_row
      win_row_shift #(
        .DATA_W(DATA_W),
        .WIN_W (WIN_W)
      ) u_row (
        .clock (clock),
        .rst   (rst),
        .clken (clken),
        .pix_in(col_in[gi*DATA_W +: DATA_W]),
        .taps  (win_out[tap_lsb(gi, 0, WIN_W, DATA_W) +: WIN_W*DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      width_q   <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      win_valid <= 1'b0;
      win_col   <= '0;
      frame_err <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (clken) begin
        if (sof) begin
          width_q   <= width;
          col_cnt   <= WIDTH_W'(1);
          row_cnt   <= '0;
          state     <= (WIN_H == 1) ? RUN : FILL;
          frame_err <= (width < WIDTH_W'(WIN_W));
          win_col   <= '0;
        end else if (state != IDLE) begin
          win_col   <= col_cnt;
          // The line-wrap pixel that promotes FILL to RUN still belongs to an incomplete line,
          // so only pixels arriving while already in RUN can complete a window.
          win_valid <= (state == RUN) && (col_cnt >= WIDTH_W'(WIN_W - 1)) && !frame_err;
          if (col_cnt == width_m1) begin
            col_cnt <= '0;
            if (row_cnt != ROW_LAST) begin
              row_cnt <= row_cnt + ROW_W'(1);
              if ((row_cnt + ROW_W'(1)) == ROW_LAST) state <= RUN;
            end
          end else begin
            col_cnt <= col_cnt + WIDTH_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_nxm.sv
// Self-checking bench for window_gen_nxm: frame-geometry table, ramp taps, clken gaps,
// mid-line sof and asynchronous reset, all against a pixel-index reference model.
module tb_window_gen_nxm;

  localparam int DATA_W  = 8;
  localparam int WIN_H   = 5;
  localparam int WIN_W   = 3;
  localparam int WIDTH_W = 11;
  localparam int CW      = WIN_H * DATA_W;
  localparam int OW      = WIN_H * WIN_W * DATA_W;

  logic               clock  = 1'b0;
  logic               rst    = 1'b0;
  logic               clken  = 1'b0;
  logic               sof    = 1'b0;
  logic [WIDTH_W-1:0] width  = '0;
  logic [CW-1:0]      col_in = '0;
  logic [OW-1:0]      win_out;
  logic               win_valid;
  logic [WIDTH_W-1:0] win_col;
  logic               frame_err;

  window_gen_nxm #(
    .DATA_W (DATA_W),
    .WIN_H  (WIN_H),
    .WIN_W  (WIN_W),
    .WIDTH_W(WIDTH_W)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .clken    (clken),
    .sof      (sof),
    .width    (width),
    .col_in   (col_in),
    .win_out  (win_out),
    .win_valid(win_valid),
    .win_col  (win_col),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: last WIN_W accepted columns plus the pixel index within the current frame.
  logic [CW-1:0] hist [WIN_W];
  bit m_active, m_err, exp_valid;
  int m_width, m_n, exp_col;

  task automatic model_reset();
    for (int c = 0; c < WIN_W; c++) hist[c] = '0;
    m_active = 0; m_err = 0; exp_valid = 0; m_width = 0; m_n = 0; exp_col = 0;
  endtask

  task automatic model_accept(input bit s, input int w, input logic [CW-1:0] d);
    int line, col;
    for (int c = 0; c < WIN_W - 1; c++) hist[c] = hist[c+1];
    hist[WIN_W-1] = d;
    exp_valid = 0;
    if (s) begin
      m_active = 1; m_width = w; m_err = (w < WIN_W); m_n = 0; exp_col = 0;
    end else if (m_active) begin
      m_n++;
      if (!m_err) begin
        line = m_n / m_width;
        col  = m_n % m_width;
        exp_col   = col;
        exp_valid = (line >= WIN_H - 1) && (col >= WIN_W - 1);
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_win();
    logic [OW-1:0] v;
    v = '0;
    for (int r = 0; r < WIN_H; r++)
      for (int c = 0; c < WIN_W; c++)
        v[(r*WIN_W+c)*DATA_W +: DATA_W] = hist[c][r*DATA_W +: DATA_W];
    return v;
  endfunction

  function automatic logic [CW-1:0] ramp(input int line, input int col);
    logic [CW-1:0] d;
    int v;
    for (int r = 0; r < WIN_H; r++) begin
      v = (line - (WIN_H - 1 - r)) * 16 + col;
      d[r*DATA_W +: DATA_W] = DATA_W'(v);
    end
    return d;
  endfunction

  function automatic logic [CW-1:0] rand_col();
    logic [CW-1:0] d;
    for (int r = 0; r < WIN_H; r++) d[r*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    return d;
  endfunction

  typedef struct {
    int            col;
    logic [OW-1:0] win;
  } win_rec_t;
  win_rec_t cap_q[$];
  bit capture = 0;

  task automatic step(input bit ce, input bit s, input int w, input logic [CW-1:0] d);
    clken  = ce;
    sof    = s;
    width  = WIDTH_W'(w);
    col_in = d;
    @(posedge clock);
    #1;
    if (ce) model_accept(s, w, d);
    else exp_valid = 0;
    check("win_valid", OW'(win_valid), OW'(exp_valid));
    check("frame_err", OW'(frame_err), OW'(m_err));
    check("win_out", win_out, exp_win());
    if (exp_valid) check("win_col", OW'(win_col), OW'(exp_col));
    if (capture && win_valid) cap_q.push_back('{int'(win_col), win_out});
  endtask

  typedef struct {
    int w;
    int lines;
    int exp_pulses;
    int exp_first;
    bit exp_err;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int cnt, first, ramp_seen, e;
    win_rec_t qa[$];
    logic [CW-1:0] fdata [48];

    vecs[0] = '{8, 5, 6, 34, 1'b0};
    vecs[1] = '{5, 5, 3, 22, 1'b0};
    vecs[2] = '{3, 6, 2, 14, 1'b0};
    vecs[3] = '{2, 6, 0, -1, 1'b1};
    vecs[4] = '{8, 7, 18, 34, 1'b0};
    vecs[5] = '{1, 6, 0, -1, 1'b1};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_win_out", win_out, '0);
    check("reset_valid", OW'(win_valid), '0);
    check("reset_col", OW'(win_col), '0);
    check("reset_err", OW'(frame_err), '0);
    @(negedge clock);
    rst = 1'b1;

    // Pixels before any sof must not produce windows.
    for (int p = 0; p < 12; p++) step(1, 0, 8, rand_col());

    ramp_seen = 0;
    foreach (vecs[i]) begin
      cnt = 0; first = -1;
      for (int p = 0; p < vecs[i].w * vecs[i].lines; p++) begin
        step(1, p == 0, vecs[i].w, ramp(p / vecs[i].w, p % vecs[i].w));
        if (win_valid) begin
          if (first < 0) first = p;
          cnt++;
          if (i == 0 && win_col == 5) begin
            ramp_seen++;
            for (int r = 0; r < WIN_H; r++)
              for (int c = 0; c < WIN_W; c++) begin
                e = r * 16 + 3 + c;
                check("ramp_tap", OW'(win_out[(r*WIN_W+c)*DATA_W +: DATA_W]), OW'(e));
              end
          end
        end
      end
      $display("vector %0d width=%0d lines=%0d pulses=%0d first=%0d err=%0b",
               i, vecs[i].w, vecs[i].lines, cnt, first, frame_err);
      check("vec_pulses", OW'(cnt), OW'(vecs[i].exp_pulses));
      check("vec_first", OW'(first), OW'(vecs[i].exp_first));
      check("vec_err", OW'(frame_err), OW'(vecs[i].exp_err));
    end
    check("ramp_seen", OW'(ramp_seen), OW'(1));

    // Same frame with and without clken gaps must yield the same window sequence.
    for (int p = 0; p < 48; p++) fdata[p] = rand_col();
    cap_q.delete();
    capture = 1;
    for (int p = 0; p < 48; p++) step(1, p == 0, 8, fdata[p]);
    qa = cap_q;
    cap_q.delete();
    for (int p = 0; p < 48; p++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(0, 0, 8, rand_col());
      step(1, p == 0, 8, fdata[p]);
    end
    capture = 0;
    $display("gap run: windows plain=%0d gapped=%0d", qa.size(), cap_q.size());
    check("gap_count", OW'(cap_q.size()), OW'(qa.size()));
    check("gap_count_abs", OW'(qa.size()), OW'(12));
    for (int k = 0; k < qa.size() && k < cap_q.size(); k++) begin
      check("gap_col", OW'(cap_q[k].col), OW'(qa[k].col));
      check("gap_win", cap_q[k].win, qa[k].win);
    end

    // sof re-asserted at column 4 of line 6.
    for (int p = 0; p < 6 * 8 + 4; p++) step(1, p == 0, 8, rand_col());
    cnt = 0; first = -1;
    for (int p = 0; p < 40; p++) begin
      step(1, p == 0, 8, rand_col());
      if (win_valid) begin
        if (first < 0) begin
          first = p;
          check("restart_col", OW'(win_col), OW'(2));
        end
        cnt++;
      end
    end
    $display("mid-line sof: first=%0d pulses=%0d", first, cnt);
    check("restart_first", OW'(first), OW'(34));
    check("restart_pulses", OW'(cnt), OW'(6));

    // Asynchronous reset while a window is being presented.
    for (int p = 0; p < 4 * 8 + 6; p++) step(1, p == 0, 8, rand_col());
    check("pre_reset_valid", OW'(win_valid), OW'(1));
    clken = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    #1;
    model_reset();
    check("async_win_out", win_out, '0);
    check("async_valid", OW'(win_valid), '0);
    check("async_col", OW'(win_col), '0);
    check("async_err", OW'(frame_err), '0);
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    cnt = 0;
    for (int p = 0; p < 48; p++) begin
      step(1, 0, 8, rand_col());
      if (win_valid) cnt++;
    end
    $display("post-reset no-sof pixels: pulses=%0d", cnt);
    check("post_reset_pulses", OW'(cnt), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
